ps2_receiver: RTL and testbench
===============================

# ps2_receiver

Deserialises the PS/2 keyboard serial stream (PS2_CLK/PS2_DAT) into validated 8-bit scan-code bytes and presents each byte as `data` with a one-cycle `data_en` strobe. It sits directly upstream of the loop/step entry decoders, which consume `data`/`data_en` and interpret make and break codes. The block is receive-only. It forwards every valid byte unmodified, including 0xF0 and 0xE0.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop synchroniser depth on PS2_CLK and PS2_DAT.
- FILTER_LEN, 8: consecutive equal synchronised PS2_CLK samples required to change the filtered clock level.
- TIMEOUT_CYCLES, 50000: idle Clock cycles allowed between filtered falling edges inside a frame (1 ms at 50 MHz).

Ports:
- Clock  in  1  system clock.
- nReset  in  1  asynchronous, active-low reset.
- PS2_CLK  in  1  raw PS/2 clock from the pin, asynchronous.
- PS2_DAT  in  1  raw PS/2 data from the pin, asynchronous.
- data  out  8  last valid received byte; reset 0x00.
- data_en  out  1  one-cycle pulse when `data` is updated; reset 0.
- frame_err  out  1  one-cycle pulse on parity, stop or timeout error; reset 0.
- busy  out  1  high while a frame is in progress (state ≠ IDLE); reset 0.

## Operation
- **Synchroniser:** both pins pass through SYNC_STAGES flops, reset to 1.
- **Filter:** `clk_f` is reset to 1. It toggles only after FILTER_LEN consecutive synchronised samples at the opposite level. `fall` is a one-cycle pulse when `clk_f` goes 1→0.
- **Data sampling:** the synchronised PS2_DAT is sampled on the cycle `fall` is high.
- **Frame format:** 11 bits: start(0), D0..D7 LSB first, odd parity, stop(1).
- **IDLE:**
  - `fall` with DAT=0 → RECV, bit counter = 0.
  - `fall` with DAT=1 → ignored; stay in IDLE.
- **RECV:** each `fall` shifts DAT into a 9-bit shift register (8 data + parity). After the 9th sample, go to STOP.
- **STOP:** the next `fall` samples the stop bit, then return to IDLE.
  - Stop=1 and odd parity over D0..D7+P: load `data`, pulse `data_en`.
  - Otherwise: pulse `frame_err` and leave `data` unchanged.
- **Timeout:**
  - The counter clears on every `fall` and on entry to IDLE.
  - It runs only in RECV and STOP.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, pulse `frame_err`, no `data_en`, shift register discarded.
- **Output exclusivity:** `data_en` and `frame_err` are never high in the same cycle. Back-to-back valid frames produce one strobe each.
- **Reset:** reset mid-frame returns to IDLE immediately and clears all outputs. A device frame still in flight is either ignored (DAT=1 at `fall`) or rejected by the parity/stop check or timeout. The block never hangs.

## Timing
- Pin to `fall`: SYNC_STAGES + FILTER_LEN Clock cycles after PS2_CLK goes low and stays low.
- `data`/`data_en`/`frame_err` are registered and change on the Clock edge after the stop-bit `fall` cycle, giving latency `fall`+1.
- `data` holds its value until the next valid frame.
- The timeout `frame_err` is asserted on the cycle after the counter hits TIMEOUT_CYCLES.
- `busy` rises the cycle after the start-bit `fall` and falls in the same cycle as the `data_en` or `frame_err` pulse.
- Glitches on PS2_CLK shorter than FILTER_LEN cycles produce no `fall`.

## Structure
- **Package `ps2_pkg`:**
  - state encoding (IDLE, RECV, STOP, one-hot);
  - FRAME_BITS=11;
  - scan-code constants shared with downstream consumers: KEY_0..KEY_9, ENTER=0x5A, BACKSPACE=0x66, RELEASE=0xF0, EXTENDED=0xE0.
- **Sub-module `ps2_clk_filter`:** synchroniser, level filter and `fall` pulse for PS2_CLK. It is instantiated once and also outputs the synchronised DAT, delay-matched to the clock path.

## Test plan
- **Valid byte 0x16:** frame bits 0,0,1,1,0,1,0,0,0,P=0,1 at 10 kHz → exactly one `data_en`, `data`=0x16, `frame_err` never high.
- **Break sequence:** frames 0xF0 (P=1) then 0x1E (P=1) back to back → two `data_en` pulses, `data`=0xF0 then 0x1E.
- **Bad parity:** 0x16 frame with P=1 → `frame_err` pulse, `data_en` low, `data` keeps previous value 0x1E.
- **Glitch:** PS2_CLK low pulses of FILTER_LEN−1 cycles in IDLE and mid-frame → no state change. Received byte still correct.
- **Timeout:** start bit plus 4 bits, then line held high for TIMEOUT_CYCLES+10 → `frame_err` pulse, `busy`=0. A following valid 0x45 frame yields `data`=0x45.
- **Reset mid-frame:** assert nReset after bit 5 → outputs 0 and IDLE. The remaining bits of that frame produce `frame_err` or nothing, never `data_en`.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive path and its downstream decoders:
//   - state_t      : receiver FSM encoding (one-hot IDLE/RECV/STOP)
//   - FRAME_BITS   : bits per PS/2 device-to-host frame
//   - PAYLOAD_BITS : bits captured into the shift register (data + parity)
//   - KEY_0..KEY_9, ENTER, BACKSPACE, RELEASE, EXTENDED : set-2 scan codes
//   - parity_ok()  : odd-parity check over data + parity
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RECV = 3'b010,
        ST_STOP = 3'b100
    } state_t;

    // start + 8 data + parity + stop
    localparam int unsigned FRAME_BITS   = 11;
    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned PAYLOAD_BITS = FRAME_BITS - 2;

    // Scan code set 2, top-row digits and editing keys
    localparam logic [7:0] KEY_0     = 8'h45;
    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_2     = 8'h1E;
    localparam logic [7:0] KEY_3     = 8'h26;
    localparam logic [7:0] KEY_4     = 8'h25;
    localparam logic [7:0] KEY_5     = 8'h2E;
    localparam logic [7:0] KEY_6     = 8'h36;
    localparam logic [7:0] KEY_7     = 8'h3D;
    localparam logic [7:0] KEY_8     = 8'h3E;
    localparam logic [7:0] KEY_9     = 8'h46;
    localparam logic [7:0] ENTER     = 8'h5A;
    localparam logic [7:0] BACKSPACE = 8'h66;
    localparam logic [7:0] RELEASE   = 8'hF0;
    localparam logic [7:0] EXTENDED  = 8'hE0;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones
    function automatic logic parity_ok(input logic [PAYLOAD_BITS-1:0] payload);
        return ^payload;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ---------------------------------------------------------------------------
// ps2_clk_filter
// Brings the raw PS/2 pins into the Clock domain, debounces the PS/2 clock
// and produces a one-cycle pulse on each filtered falling edge. The data pin
// is delayed so that o_dat reflects the pin at the moment the clock pin fell.
// Ports:
//   Clock, nReset : system clock, async active-low reset
//   i_ps2_clk     : raw PS/2 clock pin
//   i_ps2_dat     : raw PS/2 data pin
//   o_fall        : one-cycle pulse on filtered clock 1->0
//   o_dat         : synchronised data, aligned with o_fall
// SYNC_STAGES and FILTER_LEN must both be at least 2.
// ---------------------------------------------------------------------------
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 8
) (
    input  logic Clock,
    input  logic nReset,
    input  logic i_ps2_clk,
    input  logic i_ps2_dat,
    output logic o_fall,
    output logic o_dat
);

    localparam int unsigned FCNT_W = $clog2(FILTER_LEN);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic [FILTER_LEN-1:0]  r_dat_dly;
    logic [FCNT_W-1:0]      r_cnt;
    logic                   r_clk_f;
    logic                   r_fall;
    logic                   w_clk_s;
    logic                   w_dat_s;

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
    assign o_fall  = r_fall;
    assign o_dat   = r_dat_dly[FILTER_LEN-1];

    // Pin synchronisers; idle bus level is high
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
        end
    end

    // Data delayed by the filter length so it lines up with the clock path
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_dat_dly <= '1;
        end else begin
            r_dat_dly <= {r_dat_dly[FILTER_LEN-2:0], w_dat_s};
        end
    end

    // Level filter: flip only after FILTER_LEN consecutive opposite samples
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_clk_f <= 1'b1;
            r_cnt   <= '0;
            r_fall  <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (w_clk_s == r_clk_f) begin
                r_cnt <= '0;
            end else if (r_cnt == FCNT_W'(FILTER_LEN - 1)) begin
                r_cnt   <= '0;
                r_clk_f <= w_clk_s;
                // only the 1->0 transition is reported
                r_fall  <= r_clk_f;
            end else begin
                r_cnt <= r_cnt + FCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// ---------------------------------------------------------------------------
// ps2_receiver
// Receive-only PS/2 deserialiser. Each valid 11-bit frame (start, 8 data
// LSB first, odd parity, stop) is presented on data with a one-cycle
// data_en strobe; bad parity, bad stop or an inter-edge timeout gives a
// one-cycle frame_err instead. Every valid byte, including 0xF0/0xE0
// prefixes, is forwarded unmodified.
// Ports:
//   Clock, nReset : system clock, async active-low reset
//   PS2_CLK       : raw PS/2 clock pin
//   PS2_DAT       : raw PS/2 data pin
//   data          : last valid byte, held until the next valid frame
//   data_en       : one-cycle pulse when data is updated
//   frame_err     : one-cycle pulse on parity, stop or timeout error
//   busy          : high while a frame is in progress
// ---------------------------------------------------------------------------
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] data,
    output logic       data_en,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BIT_W = $clog2(PAYLOAD_BITS);

    state_t                  r_state;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic [BIT_W-1:0]        r_bitcnt;
    logic [TMO_W-1:0]        r_tmo;
    logic                    w_fall;
    logic                    w_dat;
    logic                    w_tmo_hit;

    ps2_clk_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .Clock     (Clock),
        .nReset    (nReset),
        .i_ps2_clk (PS2_CLK),
        .i_ps2_dat (PS2_DAT),
        .o_fall    (w_fall),
        .o_dat     (w_dat)
    );

    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES));

    // Frame FSM with registered outputs; a falling edge always wins over timeout
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_tmo     <= '0;
            data      <= '0;
            data_en   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            data_en   <= 1'b0;
            frame_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_tmo <= '0;
                    // a high sample at a falling edge is not a start bit
                    if (w_fall && !w_dat) begin
                        r_state  <= ST_RECV;
                        r_bitcnt <= '0;
                        busy     <= 1'b1;
                    end
                end

                ST_RECV: begin
                    if (w_fall) begin
                        r_tmo   <= '0;
                        // LSB arrives first, so shift in from the top
                        r_shift <= {w_dat, r_shift[PAYLOAD_BITS-1:1]};
                        if (r_bitcnt == BIT_W'(PAYLOAD_BITS - 1)) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_bitcnt <= r_bitcnt + BIT_W'(1);
                        end
                    end else if (w_tmo_hit) begin
                        r_state   <= ST_IDLE;
                        r_tmo     <= '0;
                        r_shift   <= '0;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                ST_STOP: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                        r_tmo   <= '0;
                        busy    <= 1'b0;
                        if (w_dat && parity_ok(r_shift)) begin
                            data    <= r_shift[DATA_BITS-1:0];
                            data_en <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        r_state   <= ST_IDLE;
                        r_tmo     <= '0;
                        r_shift   <= '0;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_tmo   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// ---------------------------------------------------------------------------
// tb_ps2_receiver
// Directed bench for ps2_receiver. Frames are driven with a short PS/2 bit
// period (HALF cycles per clock phase) and a reduced timeout so the whole
// run stays small; all expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_ps2_receiver;
    import ps2_pkg::*;

    localparam int unsigned SYNC = 2;
    localparam int unsigned FLT  = 8;
    localparam int unsigned TMO  = 400;
    localparam int          HALF = 40;
    // pin-low to registered output: SYNC + FLT to the fall pulse, +1 to register
    localparam int          LAT_OUT = SYNC + FLT + 1;
    localparam int          LAT_TMO = SYNC + FLT + TMO + 2;

    logic       Clock   = 1'b0;
    logic       nReset  = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] data;
    logic       data_en;
    logic       frame_err;
    logic       busy;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_en      = 0;
    int n_err     = 0;
    int n_both    = 0;
    int n_en_busy = 0;

    always #5 Clock = ~Clock;

    ps2_receiver #(
        .SYNC_STAGES    (SYNC),
        .FILTER_LEN     (FLT),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .data      (data),
        .data_en   (data_en),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // Pulse bookkeeping, sampled on the inactive edge
    always @(negedge Clock) begin
        if (data_en)              n_en++;
        if (frame_err)            n_err++;
        if (data_en && frame_err) n_both++;
        if (data_en && busy)      n_en_busy++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // One PS/2 bit; hit = cycles from clock-low to first data_en/frame_err (0 if none)
    task automatic send_bit(input logic b, input bit glitch, output int hit);
        hit = 0;
        PS2_DAT = b;
        if (glitch) begin
            idle(15);
            PS2_CLK = 1'b0;
            idle(FLT - 1);
            PS2_CLK = 1'b1;
            idle(HALF - 15 - (FLT - 1));
        end else begin
            idle(HALF);
        end
        PS2_CLK = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge Clock);
            if (hit == 0 && (data_en || frame_err)) hit = i;
        end
        PS2_CLK = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Full frame; hit is the stop-bit output latency
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_bit,
                              output int hit);
        logic [10:0] f;
        int h;
        f = make_frame(b, bad_par);
        hit = 0;
        for (int i = 0; i < 11; i++) begin
            send_bit(f[i], (i == glitch_bit), h);
            if (i == 10) hit = h;
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        idle(3);
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
        n_checks++; if (data_en !== 1'b0) begin n_fail++; $display("FAIL reset_data_en: got %b expected 0", data_en); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        nReset = 1'b1;
        idle(20);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
        n_checks++; if (n_en + n_err !== 0) begin n_fail++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", n_en + n_err); end
    endtask

    task automatic test_valid_byte();
        int e0, r0, hit;
        e0 = n_en; r0 = n_err;
        send_frame(KEY_1, 1'b0, -1, hit);
        idle(10);
        n_checks++; if (n_en - e0 !== 1) begin n_fail++; $display("FAIL valid_strobes: got %0d expected 1", n_en - e0); end
        n_checks++; if (data !== 8'h16) begin n_fail++; $display("FAIL valid_data: got %h expected 16", data); end
        n_checks++; if (n_err - r0 !== 0) begin n_fail++; $display("FAIL valid_no_err: got %0d expected 0", n_err - r0); end
        n_checks++; if (hit !== LAT_OUT) begin n_fail++; $display("FAIL valid_latency: got %0d expected %0d", hit, LAT_OUT); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL valid_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_busy_timing();
        logic [10:0] f;
        int lat, h;
        f = make_frame(KEY_3, 1'b0);
        PS2_DAT = 1'b0;
        idle(HALF);
        PS2_CLK = 1'b0;
        lat = 0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge Clock);
            if (lat == 0 && busy) lat = i;
        end
        PS2_CLK = 1'b1;
        n_checks++; if (lat !== LAT_OUT) begin n_fail++; $display("FAIL busy_rise: got %0d expected %0d", lat, LAT_OUT); end
        h = 0;
        for (int i = 1; i < 11; i++) send_bit(f[i], 1'b0, h);
        idle(5);
        n_checks++; if (data !== 8'h26) begin n_fail++; $display("FAIL busy_frame_data: got %h expected 26", data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int e0, r0, hit;
        e0 = n_en; r0 = n_err;
        send_frame(RELEASE, 1'b0, -1, hit);
        n_checks++; if (data !== 8'hF0) begin n_fail++; $display("FAIL b2b_first_data: got %h expected f0", data); end
        n_checks++; if (n_en - e0 !== 1) begin n_fail++; $display("FAIL b2b_first_strobe: got %0d expected 1", n_en - e0); end
        send_frame(KEY_2, 1'b0, -1, hit);
        idle(5);
        n_checks++; if (data !== 8'h1E) begin n_fail++; $display("FAIL b2b_second_data: got %h expected 1e", data); end
        n_checks++; if (n_en - e0 !== 2) begin n_fail++; $display("FAIL b2b_strobes: got %0d expected 2", n_en - e0); end
        n_checks++; if (n_err - r0 !== 0) begin n_fail++; $display("FAIL b2b_no_err: got %0d expected 0", n_err - r0); end
    endtask

    task automatic test_bad_parity();
        int e0, r0, hit;
        e0 = n_en; r0 = n_err;
        send_frame(KEY_1, 1'b1, -1, hit);
        idle(5);
        n_checks++; if (n_err - r0 !== 1) begin n_fail++; $display("FAIL parity_err_pulses: got %0d expected 1", n_err - r0); end
        n_checks++; if (n_en - e0 !== 0) begin n_fail++; $display("FAIL parity_no_strobe: got %0d expected 0", n_en - e0); end
        n_checks++; if (data !== 8'h1E) begin n_fail++; $display("FAIL parity_data_held: got %h expected 1e", data); end
        n_checks++; if (hit !== LAT_OUT) begin n_fail++; $display("FAIL parity_err_latency: got %0d expected %0d", hit, LAT_OUT); end
    endtask

    task automatic test_glitch();
        int e0, r0, hit;
        logic seen_busy;
        e0 = n_en; r0 = n_err;
        seen_busy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            PS2_CLK = 1'b0;
            idle(FLT - 1);
            PS2_CLK = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge Clock);
                if (busy) seen_busy = 1'b1;
            end
        end
        n_checks++; if (seen_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_busy: got %b expected 0", seen_busy); end
        n_checks++; if (n_en + n_err - e0 - r0 !== 0) begin n_fail++; $display("FAIL glitch_idle_pulses: got %0d expected 0", n_en + n_err - e0 - r0); end
        send_frame(ENTER, 1'b0, 4, hit);
        idle(5);
        n_checks++; if (data !== 8'h5A) begin n_fail++; $display("FAIL glitch_frame_data: got %h expected 5a", data); end
        n_checks++; if (n_en - e0 !== 1) begin n_fail++; $display("FAIL glitch_frame_strobe: got %0d expected 1", n_en - e0); end
        n_checks++; if (n_err - r0 !== 0) begin n_fail++; $display("FAIL glitch_frame_no_err: got %0d expected 0", n_err - r0); end
    endtask

    task automatic test_timeout();
        logic [10:0] f;
        int e0, r0, h, lat;
        logic busy_mid;
        f = make_frame(KEY_0, 1'b0);
        e0 = n_en; r0 = n_err;
        for (int i = 0; i < 4; i++) send_bit(f[i], 1'b0, h);
        // last data bit, then the line stays high
        PS2_DAT = f[4];
        idle(HALF);
        PS2_CLK = 1'b0;
        lat = 0;
        busy_mid = 1'b0;
        for (int i = 1; i <= TMO + 10 + HALF; i++) begin
            @(negedge Clock);
            if (lat == 0 && frame_err) lat = i;
            if (i == TMO / 2) busy_mid = busy;
            if (i == HALF) PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
        n_checks++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_mid: got %b expected 1", busy_mid); end
        n_checks++; if (lat !== LAT_TMO) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", lat, LAT_TMO); end
        n_checks++; if (n_err - r0 !== 1) begin n_fail++; $display("FAIL timeout_err_pulses: got %0d expected 1", n_err - r0); end
        n_checks++; if (n_en - e0 !== 0) begin n_fail++; $display("FAIL timeout_no_strobe: got %0d expected 0", n_en - e0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        send_frame(KEY_0, 1'b0, -1, h);
        idle(5);
        n_checks++; if (data !== 8'h45) begin n_fail++; $display("FAIL timeout_recover_data: got %h expected 45", data); end
        n_checks++; if (n_en - e0 !== 1) begin n_fail++; $display("FAIL timeout_recover_strobe: got %0d expected 1", n_en - e0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] f;
        int e0, r0, h;
        f = make_frame(KEY_1, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(f[i], 1'b0, h);
        idle(5);
        nReset = 1'b0;
        idle(1);
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h expected 00", data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_checks++; if ({data_en, frame_err} !== 2'b00) begin n_fail++; $display("FAIL midreset_pulses: got %b expected 00", {data_en, frame_err}); end
        idle(2);
        nReset = 1'b1;
        e0 = n_en; r0 = n_err;
        for (int i = 6; i < 11; i++) send_bit(f[i], 1'b0, h);
        idle(TMO + 50);
        n_checks++; if (n_en - e0 !== 0) begin n_fail++; $display("FAIL midreset_no_strobe: got %0d expected 0", n_en - e0); end
        n_checks++; if (n_err - r0 > 1) begin n_fail++; $display("FAIL midreset_err_pulses: got %0d expected at most 1", n_err - r0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_after: got %b expected 0", busy); end
        e0 = n_en;
        send_frame(BACKSPACE, 1'b0, -1, h);
        idle(5);
        n_checks++; if (data !== 8'h66) begin n_fail++; $display("FAIL midreset_recover_data: got %h expected 66", data); end
        n_checks++; if (n_en - e0 !== 1) begin n_fail++; $display("FAIL midreset_recover_strobe: got %0d expected 1", n_en - e0); end
    endtask

    task automatic test_exclusive();
        n_checks++; if (n_both !== 0) begin n_fail++; $display("FAIL exclusive_en_err: got %0d overlapping cycles expected 0", n_both); end
        n_checks++; if (n_en_busy !== 0) begin n_fail++; $display("FAIL busy_with_strobe: got %0d cycles expected 0", n_en_busy); end
    endtask

    initial begin
        test_reset();
        test_valid_byte();
        test_busy_timing();
        test_back_to_back();
        test_bad_parity();
        test_glitch();
        test_timeout();
        test_reset_mid_frame();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
